shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-step rotate controller sitting directly upstream of the RS shifter.
//  Holds the operand and drives RS's a/fbus/flbus/frbus each cycle.
//  Captures RS's w/cf back into the operand register, repeating COUNT times.
//  Then presents the result and carry with a one-cycle done pulse.
//  Gives the datapath N-bit rotates from the single-step combinational RS.
// PARAMETERS
//  WIDTH  8  operand width; must equal RS data width
//  CNT_W  3  width of step count; max rotate = 2**CNT_W-1
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst      in   1      synchronous reset, active-high
//  start    in   1      request; sampled only in IDLE
//  dir      in   1      0 = rotate left (flbus), 1 = rotate right (frbus)
//  count    in   CNT_W  number of single-bit rotate steps
//  din      in   WIDTH  operand, captured with start
//  sh_a     out  WIDTH  to RS.a (operand register)
//  sh_fbus  out  1      to RS.fbus (pass-through)
//  sh_flbus out  1      to RS.flbus
//  sh_frbus out  1      to RS.frbus
//  sh_w     in   WIDTH  from RS.w; high-Z when no RS control is asserted
//  sh_cf    in   1      from RS.cf
//  dout     out  WIDTH  result, held until next accepted start
//  cf_out   out  1      carry of final step, held with dout
//  busy     out  1      high in SHIFT/PASS/DONE
//  done     out  1      one-cycle pulse; dout/cf_out valid from this cycle
// BEHAVIOUR
//  - Reset: state=IDLE; sh_a, dout = 0; cf_out, busy, done = 0; all sh_* controls = 0.
//  - States: IDLE, SHIFT, PASS, DONE (registered).
//  - IDLE: controls 0; on start=1 load opnd<=din, cnt<=count, dir_r<=dir.
//    Next state is SHIFT if count!=0, else PASS.
//  - SHIFT: exactly one of sh_flbus/sh_frbus=1 per dir_r; sh_fbus=0.
//    Each edge: opnd<=sh_w, cf_r<=sh_cf, cnt<=cnt-1; cnt==1 -> DONE.
//  - PASS (count=0): sh_fbus=1 one cycle; opnd<=sh_w, cf_r<=sh_cf (RS gives 0) -> DONE.
//  - DONE: controls 0, done=1, dout=opnd, cf_out=cf_r; -> IDLE unconditionally.
//  - Controls are decoded from registered state only, never from inputs.
//    They are one-hot or all-zero; never two asserted together.
//  - sh_w is never sampled in IDLE/DONE, because it is high-Z there.
//  - Latency: start accepted at edge E0; done high in the cycle after edge E0+max(count,1).
//    Back-to-back issue period = max(count,1)+2 cycles.
//  - start in SHIFT/PASS/DONE is ignored. din/dir/count changes after acceptance have no effect.
//  - dout/cf_out change only on entry to DONE; stable otherwise.
//  - rst mid-operation: aborts at the next edge to reset values; no done pulse is issued.
//  - cnt is CNT_W bits, decrement only in SHIFT, no wrap (exit at 1).
// STRUCTURE
//  - Shared package cpu_pkg: state enum {IDLE,SHIFT,PASS,DONE}, DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
//  - Single flat module; no sub-module.
//  - RS is instantiated beside this block in the datapath and in the bench.
// TESTING (bench instantiates shift_sequencer + RS)
//  1. din=8'h81, dir=0, count=1 -> done after E0+1; dout=8'h03, cf_out=1.
//  2. din=8'h01, dir=1, count=3 -> sh_a 01,80,40; dout=8'h20, cf_out=0.
//     done after E0+3; sh_frbus high exactly 3 cycles.
//  3. din=8'hA5, count=0 -> sh_fbus high 1 cycle; dout=8'hA5, cf_out=0, done after E0+1.
//  4. din=8'h01, dir=0, count=7; start pulsed during busy -> ignored.
//     dout=8'h80, cf_out=0; busy 8 cycles incl. DONE.
//  5. count=5 run, rst at 2nd SHIFT cycle -> next cycle: all controls 0, busy=0, dout=0, no done.
//     A subsequent start completes normally.
//  6. start held high, count=2 -> accepts every 4 cycles; every done is one cycle wide.
//     Assert controls never multi-hot, with a checker on all cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state and direction definitions for the rotate sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PASS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rs.sv
// rtl/rs.sv - single-step combinational rotate shifter; w floats when no control is asserted
module rs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             fbus,
  input  logic             flbus,
  input  logic             frbus,
  output logic [WIDTH-1:0] w,
  output logic             cf
);

  logic [WIDTH-1:0] w_val;

  always_comb begin
    w_val = a;
    cf    = 1'b0;
    if (flbus) begin
      w_val = {a[WIDTH-2:0], a[WIDTH-1]};
      cf    = a[WIDTH-1];
    end else if (frbus) begin
      w_val = {a[0], a[WIDTH-1:1]};
      cf    = a[0];
    end
  end

  assign w = (fbus | flbus | frbus) ? w_val : {WIDTH{1'bz}};

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step rotate controller driving the RS shifter one bit per cycle
module shift_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sh_a,
  output logic             sh_fbus,
  output logic             sh_flbus,
  output logic             sh_frbus,
  input  logic [WIDTH-1:0] sh_w,
  input  logic             sh_cf,
  output logic [WIDTH-1:0] dout,
  output logic             cf_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic             last_step;

  assign last_step = (cnt == CNT_W'(1));

  // The result registers load on the same edge that enters DONE, so dout is valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opnd   <= '0;
      cnt    <= '0;
      dir_r  <= DIR_LEFT;
      dout   <= '0;
      cf_out <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            opnd  <= din;
            cnt   <= count;
            dir_r <= dir;
          end
        end
        SHIFT: begin
          opnd <= sh_w;
          cnt  <= cnt - CNT_W'(1);
          if (last_step) begin
            dout   <= sh_w;
            cf_out <= sh_cf;
          end
        end
        PASS: begin
          opnd   <= sh_w;
          dout   <= sh_w;
          cf_out <= sh_cf;
        end
        default: ;
      endcase
    end
  end

  // Controls depend only on registered state, so they stay glitch-free and one-hot.
  always_comb begin
    state_nx = state;
    sh_fbus  = 1'b0;
    sh_flbus = 1'b0;
    sh_frbus = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nx = (count != '0) ? SHIFT : PASS;
      end
      SHIFT: begin
        sh_flbus = (dir_r == DIR_LEFT);
        sh_frbus = (dir_r == DIR_RIGHT);
        if (last_step) state_nx = DONE;
      end
      PASS: begin
        sh_fbus  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sh_a = opnd;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer paired with RS
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic [2:0] count;
  logic [7:0] din;
  logic [7:0] sh_a;
  logic       sh_fbus;
  logic       sh_flbus;
  logic       sh_frbus;
  wire  [7:0] sh_w;
  wire        sh_cf;
  logic [7:0] dout;
  logic       cf_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  int lat, nfl, nfr, nfb, nbusy;
  logic [7:0] sa_q[$];

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .count(count), .din(din),
    .sh_a(sh_a), .sh_fbus(sh_fbus), .sh_flbus(sh_flbus), .sh_frbus(sh_frbus),
    .sh_w(sh_w), .sh_cf(sh_cf), .dout(dout), .cf_out(cf_out), .busy(busy), .done(done)
  );

  rs #(.WIDTH(8)) u_rs (
    .a(sh_a), .fbus(sh_fbus), .flbus(sh_flbus), .frbus(sh_frbus), .w(sh_w), .cf(sh_cf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      assert ($countones({sh_fbus, sh_flbus, sh_frbus}) <= 1) n_pass++;
      else $error("FAIL multihot: observed %b expected at most one set", {sh_fbus, sh_flbus, sh_frbus});
    end
  end

  // Issues one start, scrambles inputs after acceptance, and traces until done (bounded).
  task automatic run(input logic [7:0] d, input logic dr, input logic [2:0] c, input int pulse_at);
    @(negedge clk);
    start = 1'b1; din = d; dir = dr; count = c;
    @(negedge clk);
    start = 1'b0; din = ~d; dir = ~dr; count = ~c;
    lat = -1; nfl = 0; nfr = 0; nfb = 0; nbusy = 0;
    sa_q.delete();
    for (int j = 0; j < 20; j++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = j;
        break;
      end
      sa_q.push_back(sh_a);
      nfl += int'(sh_flbus);
      nfr += int'(sh_frbus);
      nfb += int'(sh_fbus);
      start = (j == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic after_done(input string tag, input logic [7:0] exp_dout);
    @(negedge clk);
    chk({tag, "_done_cleared"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_dout_held"}, dout, exp_dout);
  endtask

  initial begin
    int ndone, first_done, last_idx, bad_gap, wide, bad_dout, prev_done;

    rst = 1'b1; start = 1'b0; dir = 1'b0; count = 3'd0; din = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sh_a", sh_a, 8'h00);
    chk("rst_dout", dout, 8'h00);
    chk("rst_cf_out", cf_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctrl", {sh_fbus, sh_flbus, sh_frbus}, 3'b000);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: single left rotate with carry out
    run(8'h81, 1'b0, 3'd1, -1);
    chk("t1_lat", lat, 1);
    chk("t1_dout", dout, 8'h03);
    chk("t1_cf", cf_out, 1);
    chk("t1_flbus_cycles", nfl, 1);
    chk("t1_frbus_cycles", nfr, 0);
    after_done("t1", 8'h03);

    // 2: three right rotates
    run(8'h01, 1'b1, 3'd3, -1);
    chk("t2_lat", lat, 3);
    chk("t2_sh_a0", sa_q.size() > 0 ? sa_q[0] : 8'hxx, 8'h01);
    chk("t2_sh_a1", sa_q.size() > 1 ? sa_q[1] : 8'hxx, 8'h80);
    chk("t2_sh_a2", sa_q.size() > 2 ? sa_q[2] : 8'hxx, 8'h40);
    chk("t2_frbus_cycles", nfr, 3);
    chk("t2_flbus_cycles", nfl, 0);
    chk("t2_dout", dout, 8'h20);
    chk("t2_cf", cf_out, 0);
    after_done("t2", 8'h20);

    // 3: zero count passes the operand through
    run(8'hA5, 1'b1, 3'd0, -1);
    chk("t3_lat", lat, 1);
    chk("t3_fbus_cycles", nfb, 1);
    chk("t3_rot_cycles", nfl + nfr, 0);
    chk("t3_dout", dout, 8'hA5);
    chk("t3_cf", cf_out, 0);
    after_done("t3", 8'hA5);

    // 4: maximum count with a stray start while busy
    run(8'h01, 1'b0, 3'd7, 3);
    chk("t4_lat", lat, 7);
    chk("t4_busy_cycles", nbusy, 8);
    chk("t4_flbus_cycles", nfl, 7);
    chk("t4_dout", dout, 8'h80);
    chk("t4_cf", cf_out, 0);
    after_done("t4", 8'h80);

    // 5: reset during the second shift cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1; din = 8'h5A; dir = 1'b0; count = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_in_shift", sh_flbus, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_ctrl", {sh_fbus, sh_flbus, sh_frbus}, 3'b000);
    chk("t5_busy", busy, 0);
    chk("t5_dout", dout, 8'h00);
    chk("t5_done", done, 0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("t5_no_done_after", ndone, 0);
    run(8'h03, 1'b1, 3'd2, -1);
    chk("t5_post_lat", lat, 2);
    chk("t5_post_dout", dout, 8'hC0);
    chk("t5_post_cf", cf_out, 1);
    after_done("t5_post", 8'hC0);

    // 6: start held high back-to-back
    @(negedge clk);
    start = 1'b1; din = 8'h05; dir = 1'b0; count = 3'd2;
    ndone = 0; first_done = -1; last_idx = -1; bad_gap = 0; wide = 0; bad_dout = 0; prev_done = 0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = j;
        if (last_idx >= 0 && j - last_idx != 4) bad_gap++;
        if (prev_done != 0) wide++;
        if (dout !== 8'h14 || cf_out !== 1'b0) bad_dout++;
        last_idx = j;
      end
      prev_done = int'(done);
    end
    start = 1'b0;
    chk("t6_done_count", ndone, 4);
    chk("t6_first_done", first_done, 2);
    chk("t6_period", bad_gap, 0);
    chk("t6_pulse_width", wide, 0);
    chk("t6_result", bad_dout, 0);
    for (int j = 0; j < 10 && busy; j++) @(negedge clk);
    chk("t6_drained", busy, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
